// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the RV32M/RV64M multiply/divide unit
package muldiv_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one bit-serial step of shift-add multiply or restoring divide
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] acc_hi_n,
  output logic [XLEN-1:0] acc_lo_n
);

  // Multiply: {acc_hi,acc_lo} holds partial product over the shifting multiplier.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub_low;
  logic            fits;

  // Compute the next accumulator pair for the selected operation.
  always_comb begin
    add_sum  = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
    shifted  = {acc_hi, acc_lo[XLEN-1]};
    fits     = (shifted >= {1'b0, opnd});
    // The remainder stays below the divisor, so a successful subtract fits in XLEN bits.
    sub_low  = shifted[XLEN-1:0] - opnd;
    acc_hi_n = add_sum[XLEN:1];
    acc_lo_n = {add_sum[0], acc_lo[XLEN-1:1]};
    if (is_div) begin
      if (fits) begin
        acc_hi_n = sub_low;
        acc_lo_n = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        acc_hi_n = shifted[XLEN-1:0];
        acc_lo_n = {acc_lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV M-extension multiply/divide unit with handshakes
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic              accept, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, sgn_ovf, fast;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div   (f3_q[2]),
    .acc_hi   (hi_q),
    .acc_lo   (lo_q),
    .opnd     (opnd_q),
    .acc_hi_n (hi_n),
    .acc_lo_n (lo_n)
  );

  // Decode the request, take operand magnitudes and spot the single-cycle divide cases.
  always_comb begin
    accept   = in_valid && in_ready && !flush && (opcode == OP_REG) && (funct7 == F7_MULDIV);
    a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    b_signed = a_signed && (funct3 != F3_MULHSU);
    a_neg    = a_signed && rs1[XLEN-1];
    b_neg    = b_signed && rs2[XLEN-1];
    mag_a    = a_neg ? -rs1 : rs1;
    mag_b    = b_neg ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    sgn_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    fast     = funct3[2] && (div_zero || sgn_ovf);
    if (div_zero) begin
      fast_res = funct3[1] ? rs1 : '1;
    end else begin
      fast_res = funct3[1] ? '0 : rs1;
    end
  end

  // Apply the sign fix-up to the outcome of the final iteration.
  always_comb begin
    prod     = {hi_n, lo_n};
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -lo_n : lo_n;
    rem_fix  = a_neg_q ? -hi_n : hi_n;
    if (f3_q[2]) begin
      calc_res = f3_q[1] ? rem_fix : quo_fix;
    end else begin
      calc_res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    f3_d        = f3_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d    = funct3;
          a_neg_d = a_neg;
          b_neg_d = b_neg;
          cnt_d   = CNT_W'(XLEN);
          hi_d    = '0;
          lo_d    = funct3[2] ? mag_a : mag_b;
          opnd_d  = funct3[2] ? mag_b : mag_a;
          if (fast) begin
            state_d     = DONE;
            result_d    = fast_res;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          result_d    = calc_res;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      f3_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      f3_q        <= f3_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [6:0]      opcode = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;

  int              n_tests = 0;
  int              n_fail = 0;
  logic [31:0]     last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of an M instruction, from the ISA rules with plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = longint'({32'b0, a}) * longint'({32'b0, b}); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Issue one request and follow it through DONE back to IDLE.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int stall);
    int lat;
    int exp_lat;
    exp_lat = is_fast(f3, a, b) ? 1 : XLEN + 1;
    @(negedge clk);
    chk({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    opcode    = OP_REG;
    funct7    = F7_MULDIV;
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, 64'(result), 64'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " stall result"}, 64'(result), 64'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " in_ready after"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid after"}, 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    last_res  = exp;
  endtask

  // Accept a MUL and advance to CALC cycle 10.
  task automatic start_and_wait10();
    @(negedge clk);
    opcode   = OP_REG;
    funct7   = F7_MULDIV;
    funct3   = F3_MUL;
    rs1      = 32'd123;
    rs2      = 32'd456;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          seen;

    repeat (3) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    rst_n = 1'b1;

    run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", F3_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_op("divu0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem0", F3_REM, 32'd5, 32'd0, 32'd5, 0);
    run_op("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("removf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    // A non-M R-type request must be ignored.
    @(negedge clk);
    opcode    = OP_REG;
    funct7    = 7'b0000000;
    funct3    = F3_MUL;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!in_ready || out_valid) seen = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("non-M ignored", 64'(seen), 64'd0);

    // Flush in the middle of CALC.
    start_and_wait10();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush result held", 64'(result), 64'(last_res));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush no output", 64'(seen), 64'd0);
    run_op("mul after flush", F3_MUL, 32'd12345, 32'd678, model(F3_MUL, 32'd12345, 32'd678), 0);

    // Asynchronous reset in the middle of CALC.
    start_and_wait10();
    rst_n = 1'b0;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul after rst", F3_MUL, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFF7, 0);

    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op($sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b, model(f3, a, b),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
